// File: rtl/axi4_sram_slave_if.sv
// axi4_if: AXI4 bus bundle shared by the SRAM slave and its master.
// Burst-capable subset only: no SIZE/LOCK/CACHE/PROT/QOS channels,
// since the slave always transfers full data-width beats.
//   slave  modport: receives AW/W/AR/B-ready/R-ready;
//                   drives AWREADY, WREADY, B*, ARREADY, R*.
//   master modport: the mirror image.
interface axi4_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4
);
  logic [AXI4_ID_WIDTH-1:0]        awid;
  logic [AXI4_ADDRESS_WIDTH-1:0]   awaddr;
  logic [7:0]                      awlen;
  logic [1:0]                      awburst;
  logic                            awvalid;
  logic                            awready;

  logic [AXI4_DATA_WIDTH-1:0]      wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]    wstrb;
  logic                            wlast;
  logic                            wvalid;
  logic                            wready;

  logic [AXI4_ID_WIDTH-1:0]        bid;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;

  logic [AXI4_ID_WIDTH-1:0]        arid;
  logic [AXI4_ADDRESS_WIDTH-1:0]   araddr;
  logic [7:0]                      arlen;
  logic [1:0]                      arburst;
  logic                            arvalid;
  logic                            arready;

  logic [AXI4_ID_WIDTH-1:0]        rid;
  logic [AXI4_DATA_WIDTH-1:0]      rdata;
  logic [1:0]                      rresp;
  logic                            rlast;
  logic                            rvalid;
  logic                            rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 slave in front of a word-addressed SRAM of
// 2**MEM_ADDR_BITS words. Independent write (W_IDLE/W_DATA/W_RESP) and
// read (R_IDLE/R_DATA) state machines run concurrently, one burst each.
// WRAP bursts are handled as INCR; FIXED bursts stay on one word.
// Address bits above the memory index are ignored (aliasing).
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset (control only; memory keeps data)
//   s    - axi4_if.slave bus
//
// Build option: define AXI4_SRAM_SLAVE_STALL_EN to gate AWREADY, WREADY and
// ARREADY with a free-running toggle bit (ready only every other cycle).
module axi4_sram_slave #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int MEM_ADDR_BITS      = 10
) (
  input  logic  clk,
  input  logic  rst,
  axi4_if.slave s
);
  localparam int BYTES = AXI4_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int DEPTH = 2 ** MEM_ADDR_BITS;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [MEM_ADDR_BITS-1:0] next_idx(
    input logic [MEM_ADDR_BITS-1:0] idx,
    input logic [1:0]               burst
  );
    return (burst == BURST_FIXED) ? idx : idx + MEM_ADDR_BITS'(1);
  endfunction

  logic [AXI4_DATA_WIDTH-1:0] mem [DEPTH];

  logic gate;
`ifdef AXI4_SRAM_SLAVE_STALL_EN
  logic toggle;
  always_ff @(posedge clk) begin
    if (rst) toggle <= 1'b0;
    else     toggle <= ~toggle;
  end
  assign gate = toggle;
`else
  assign gate = 1'b1;
`endif

  logic [MEM_ADDR_BITS-1:0] aw_idx, ar_idx;
  assign aw_idx = s.awaddr[LSB +: MEM_ADDR_BITS];
  assign ar_idx = s.araddr[LSB +: MEM_ADDR_BITS];

  // Low (sub-word) and high (aliased) address bits are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{s.awaddr, s.araddr};

  // ---------------- write channel ----------------
  w_state_t                 w_state, w_next;
  logic [AXI4_ID_WIDTH-1:0] aw_id_q;
  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic [7:0]               w_len, w_beat;
  logic [1:0]               w_burst;
  logic                     w_err;
  logic                     aw_fire, w_fire;

  assign aw_fire = s.awvalid && s.awready;
  assign w_fire  = s.wvalid && s.wready;

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && (w_beat == w_len)) w_next = W_RESP;
      W_RESP:  if (s.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Outputs are forced low during reset so nothing handshakes on that edge.
  always_comb begin
    s.awready = 1'b0;
    s.wready  = 1'b0;
    s.bvalid  = 1'b0;
    s.bid     = '0;
    s.bresp   = 2'b00;
    if (!rst) begin
      unique case (w_state)
        W_IDLE:  s.awready = gate;
        W_DATA:  s.wready  = gate;
        W_RESP: begin
          s.bvalid = 1'b1;
          s.bid    = aw_id_q;
          s.bresp  = w_err ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  // The burst always ends on beat AWLEN; a WLAST that disagrees only
  // flags the error, it never shortens or extends the burst.
  always_ff @(posedge clk) begin
    if (aw_fire) begin
      aw_id_q <= s.awid;
      w_idx   <= aw_idx;
      w_len   <= s.awlen;
      w_burst <= s.awburst;
      w_beat  <= 8'd0;
      w_err   <= 1'b0;
    end else if (w_fire) begin
      w_beat <= w_beat + 8'd1;
      w_idx  <= next_idx(w_idx, w_burst);
      if (s.wlast != (w_beat == w_len)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s.wstrb[b]) mem[w_idx][8*b +: 8] <= s.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t                   r_state, r_next;
  logic [AXI4_ID_WIDTH-1:0]   ar_id_q;
  logic [MEM_ADDR_BITS-1:0]   r_idx, r_idx_nxt;
  logic [7:0]                 r_len, r_beat;
  logic [1:0]                 r_burst;
  logic [AXI4_DATA_WIDTH-1:0] rdata_q;
  logic                       ar_fire, r_fire;

  assign ar_fire   = s.arvalid && s.arready;
  assign r_fire    = s.rvalid && s.rready;
  assign r_idx_nxt = next_idx(r_idx, r_burst);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (r_fire && (r_beat == r_len)) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s.arready = 1'b0;
    s.rvalid  = 1'b0;
    s.rid     = '0;
    s.rdata   = '0;
    s.rresp   = 2'b00;
    s.rlast   = 1'b0;
    if (!rst) begin
      unique case (r_state)
        R_IDLE: s.arready = gate;
        R_DATA: begin
          s.rvalid = 1'b1;
          s.rid    = ar_id_q;
          s.rdata  = rdata_q;
          s.rlast  = (r_beat == r_len);
        end
        default: ;
      endcase
    end
  end

  // RDATA is sampled once per beat (at AR accept or at the previous beat's
  // handshake), so a held beat never changes under a concurrent write.
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      ar_id_q <= s.arid;
      r_idx   <= ar_idx;
      r_len   <= s.arlen;
      r_burst <= s.arburst;
      r_beat  <= 8'd0;
      rdata_q <= mem[ar_idx];
    end else if (r_fire && (r_beat != r_len)) begin
      r_beat  <= r_beat + 8'd1;
      r_idx   <= r_idx_nxt;
      rdata_q <= mem[r_idx_nxt];
    end
  end
endmodule

// File: doc/axi4_sram_slave.md
AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

Interface
REQ-001 SHALL have parameter AXI4_ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter AXI4_DATA_WIDTH, default 32, data width (power of two, >=32).
REQ-003 SHALL have parameter AXI4_ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter MEM_ADDR_BITS, default 10, log2 of memory depth in data words.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port s  axi4_if.slave  -  AXI4 slave port; drives AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID.

Function
REQ-008 SHALL contain a word-addressed memory of 2**MEM_ADDR_BITS words; word index = addr[MEM_ADDR_BITS+log2(DW/8)-1 : log2(DW/8)]; upper bits ignored (aliasing, no error).
REQ-009 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE; AW handshake captures AWID, AWADDR, AWLEN, AWBURST and moves to W_DATA.
REQ-010 In W_DATA, WREADY SHALL be 1; each W handshake writes byte lanes with WSTRB[i]=1 to the current word; lanes with WSTRB[i]=0 unchanged.
REQ-011 Address SHALL advance by DW/8 bytes per beat for INCR and WRAP (WRAP treated as INCR); FIXED SHALL not advance; index wraps modulo depth.
REQ-012 Write burst SHALL end on beat AWLEN (beats counted 0..AWLEN) regardless of WLAST, then enter W_RESP.
REQ-013 If WLAST differs from (beat==AWLEN) on any beat, BRESP SHALL be SLVERR (2'b10); else OKAY (2'b00); data still written.
REQ-014 In W_RESP, BVALID=1 with BID=captured AWID; SHALL hold until BREADY, then return to W_IDLE; next AWREADY no earlier than the following cycle.
REQ-015 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; AR handshake captures ARID, ARADDR, ARLEN, ARBURST; RVALID asserts the next cycle (1-cycle latency).
REQ-016 In R_DATA, RDATA SHALL be the current word, RID=captured ARID, RRESP=OKAY, RLAST=(beat==ARLEN); address rule per REQ-011.
REQ-017 RVALID, RDATA, RLAST SHALL remain stable while RVALID=1 and RREADY=0; after the RLAST handshake, return to R_IDLE.
REQ-018 Read and write FSMs SHALL operate concurrently; a write to a word being read becomes visible on RDATA the cycle after the write edge, never within a held beat (REQ-017 takes precedence: RDATA registered per beat).
REQ-019 One outstanding transaction per direction; no reordering; ID only echoed.

Reset
REQ-020 While rst=1, both FSMs SHALL go idle; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST SHALL be 0; BID, BRESP, RID, RDATA, RRESP 0.
REQ-021 Reset mid-burst SHALL abandon the burst with no B/R response; beats already written remain; memory contents not reset.
REQ-022 First cycle after rst deasserts, AWREADY=1 and ARREADY=1.

Configuration
REQ-023 With AXI4_SRAM_SLAVE_STALL_EN defined, a free-running toggle bit (0 at reset) SHALL gate AWREADY, WREADY and ARREADY (asserted only when toggle=1); VALID outputs never gated.
REQ-024 Without AXI4_SRAM_SLAVE_STALL_EN, no gating; full-throughput 1 beat/cycle.

Verification
REQ-025 AW addr=0x10,len=3,INCR,id=5; W 0xA0..0xA3, WLAST on beat 3 -> BVALID, BID=5, BRESP=OKAY; AR same -> RDATA 0xA0..0xA3, RLAST on 4th, RID=5.
REQ-026 Write 0xFFFFFFFF to 0x0, then 0x12345678 with WSTRB=4'b0101 -> read returns 0xFF34FF78.
REQ-027 AW len=1, WLAST on beat 0 -> two beats written, BRESP=2'b10.
REQ-028 Read len=2 with RREADY low 3 cycles per beat -> RDATA/RLAST stable while stalled, 3 beats total.
REQ-029 rst pulse during beat 2 of 4-beat write -> no BVALID, AWREADY=1 next cycle post-reset, beats 0-1 readable.
REQ-030 STALL_EN defined, len=7 write -> WREADY alternates, all 8 beats correct, BRESP=OKAY.
